// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage with a 2-entry skid buffer. It carries an opaque
//   DATA_W-bit payload between two pipeline stages using valid/ready
//   handshakes. in_ready is registered, so there is no combinational path
//   from out_ready to in_ready. flush turns every held entry into a bubble.
//
// Optional feature:
//   PIPE_STALL_CNT_EN - when defined, adds the stall_cnt output. This is a
//   16-bit saturating count of cycles with out_valid=1 and out_ready=0.
//   Only rst clears it.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   flush      in   1       synchronous kill of all held entries
//   in_valid   in   1       upstream has a payload
//   in_ready   out  1       stage can accept (registered)
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a live payload
//   out_ready  in   1       downstream accepts this cycle
//   out_data   out  DATA_W  payload to downstream, BUBBLE_VAL when idle
//   occupancy  out  2       entries held (0, 1, 2)
//   stall_cnt  out  16      stall cycle counter (PIPE_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // The state encoding equals the occupancy, so occupancy comes straight from the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] skid_r;
  logic [DATA_W-1:0] main_nxt_s;
  logic [DATA_W-1:0] skid_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // State, payload and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_r      <= BUBBLE_VAL;
      skid_r      <= BUBBLE_VAL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      // in_ready and out_valid are decoded from the next state so that both leave a flop.
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Next-state logic. flush overrides every handshake.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) state_nxt_s = ST_ONE;
          else           state_nxt_s = ST_EMPTY;
        end
        ST_ONE: begin
          if (in_fire_s && !out_ready)      state_nxt_s = ST_FULL;
          else if (!in_fire_s && out_fire_s) state_nxt_s = ST_EMPTY;
          else                               state_nxt_s = ST_ONE;
        end
        ST_FULL: begin
          if (out_fire_s) state_nxt_s = ST_ONE;
          else            state_nxt_s = ST_FULL;
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // Payload movement between the input, the main register and the skid register.
  always_comb begin
    main_nxt_s = main_r;
    skid_nxt_s = skid_r;
    if (flush) begin
      main_nxt_s = BUBBLE_VAL;
      skid_nxt_s = BUBBLE_VAL;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) main_nxt_s = in_data;
          else           main_nxt_s = main_r;
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_nxt_s = in_data;
          end else if (in_fire_s) begin
            // Downstream is stalled, so the new payload parks in the skid register.
            skid_nxt_s = in_data;
          end else if (out_fire_s) begin
            main_nxt_s = BUBBLE_VAL;
          end else begin
            main_nxt_s = main_r;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            main_nxt_s = skid_r;
            skid_nxt_s = BUBBLE_VAL;
          end else begin
            main_nxt_s = main_r;
          end
        end
        default: begin
          main_nxt_s = BUBBLE_VAL;
          skid_nxt_s = BUBBLE_VAL;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = state_r;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of downstream stall cycles. flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Directed test of pipe_stage_skid with DATA_W=32 and a zero bubble. Inputs
//   change 1 time unit after each rising edge, and outputs are checked at that
//   same point.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total;
  int bad;

  pipe_stage_skid #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 32'h0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_occ", {30'b0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // Streaming: three back-to-back transfers, downstream always ready.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h11;
    tick();
    chk("str_d0", out_data, 32'h11);
    chk("str_v0", {31'b0, out_valid}, 32'd1);
    in_data = 32'h22;
    tick();
    chk("str_d1", out_data, 32'h22);
    chk("str_rdy1", {31'b0, in_ready}, 32'd1);
    in_data = 32'h33;
    tick();
    chk("str_d2", out_data, 32'h33);
    chk("str_rdy2", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("str_drain_v", {31'b0, out_valid}, 32'd0);
    chk("str_drain_d", out_data, 32'h0);

    // Backpressure: fill both entries, then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA1;
    tick();
    chk("bp_occ1", {30'b0, occupancy}, 32'd1);
    in_data = 32'hB2;
    tick();
    chk("bp_occ2", {30'b0, occupancy}, 32'd2);
    chk("bp_rdy0", {31'b0, in_ready}, 32'd0);
    in_data = 32'hC3;
    tick();
    chk("bp_hold_d", out_data, 32'hA1);
    chk("bp_hold_occ", {30'b0, occupancy}, 32'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b2", out_data, 32'hB2);
    chk("bp_rdy1", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_out_c3", out_data, 32'hC3);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush while full with a concurrent input that must be dropped.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h01;
    tick();
    in_data = 32'h02;
    tick();
    chk("fl_pre_occ", {30'b0, occupancy}, 32'd2);
    flush = 1'b1;
    in_data = 32'hDD;
    tick();
    chk("fl_v", {31'b0, out_valid}, 32'd0);
    chk("fl_d", out_data, 32'h0);
    chk("fl_occ", {30'b0, occupancy}, 32'd0);
    chk("fl_rdy", {31'b0, in_ready}, 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_no_dd_v", {31'b0, out_valid}, 32'd0);
    chk("fl_no_dd_d", out_data, 32'h0);

    // Reset mid-cycle while full: the outputs must clear without waiting for a clock edge.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h44;
    tick();
    in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_v", {31'b0, out_valid}, 32'd0);
    chk("mrst_d", out_data, 32'h0);
    chk("mrst_occ", {30'b0, occupancy}, 32'd0);
    tick();
    rst = 1'b0;
    chk("mrst_rdy", {31'b0, in_ready}, 32'd1);

    // Idle hold: one entry stalled for 10 cycles.
    in_valid = 1'b1;
    in_data = 32'h5A;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("idle_d", out_data, 32'h5A);
    chk("idle_v", {31'b0, out_valid}, 32'd1);
`ifdef PIPE_STALL_CNT_EN
    chk("idle_cnt", {16'b0, stall_cnt}, 32'd10);
    // Saturation: the counter must stop at its maximum value and not wrap.
    repeat (70000) tick();
    chk("sat_cnt", {16'b0, stall_cnt}, 32'h0000FFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_flush_keep", {16'b0, stall_cnt}, 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor of the fixed ID→EX pipeline register.
- Generic pipeline stage carrying an opaque DATA_W-bit payload (aluop, alusel, operands, wd, wreg, link address, inst, excepttype, pc, etc. concatenated by the instantiator).
- Replaces the global stall vector with per-stage valid/ready handshakes and a 2-entry skid buffer, so in_ready is a registered signal with no combinational ready path.
- Keeps flush-to-bubble semantics; instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, payload width in bits (1..1024).
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data when no valid entry (NOP encoding).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (exception/eret).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload to downstream; BUBBLE_VAL when out_valid=0.
- occupancy  out  2  entries held (0,1,2).
- stall_cnt  out  16  only with PIPE_STALL_CNT_EN (see below).

Behaviour:
- Storage: main register (drives out_data) plus skid register. States EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
- Reset (async, immediate, also mid-transfer): state EMPTY, out_valid=0, out_data=BUBBLE_VAL, skid=BUBBLE_VAL, in_ready=1, occupancy=0, stall_cnt=0. First accept possible on the first rising edge after rst deasserts.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. in_valid must not depend on in_ready. out_ready may depend on out_valid.
- Latency: 1 cycle in_fire → out_valid. Throughput: 1/cycle while out_ready=1.
- EMPTY: in_fire → main<=in_data, ONE.
- ONE:
  - in_fire & out_fire → main<=in_data, stay ONE.
  - in_fire & !out_ready → skid<=in_data, FULL.
  - !in_fire & out_fire → main<=BUBBLE_VAL, EMPTY.
  - Otherwise hold.
- FULL: in_ready=0.
  - out_fire → main<=skid, skid<=BUBBLE_VAL, ONE.
  - Otherwise hold both.
- in_ready (registered) = next_state != FULL. Deasserts the cycle after the skid loads. Reasserts the cycle after FULL drains.
- flush has priority over everything:
  - Next state EMPTY; main and skid <= BUBBLE_VAL; in_ready=1 next cycle.
  - A concurrent in_fire is dropped.
  - A concurrent out_fire is still consumed by downstream; the downstream stage is responsible for its own flush.
- Payload order strictly FIFO. No payload is lost or duplicated absent flush.
- Payload bits are never inspected or modified. Width arithmetic: none beyond the 2-bit occupancy.

Optional Feature:
- Macro PIPE_STALL_CNT_EN.
- Defined: stall_cnt port exists.
  - Increments by 1 each cycle with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset: rst=1 mid-stream with occupancy=2 → same cycle out_valid=0, out_data=0, occupancy=0; in_ready=1 after release.
- Streaming: in_valid=1 with 0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data 0x11,0x22,0x33 on cycles 1,2,3; in_ready stays 1.
- Backpressure: out_ready=0, push 0xA1,0xB2 → occupancy=2, in_ready=0 next cycle, 0xC3 held upstream. Raise out_ready → outputs 0xA1,0xB2,0xC3 in order, no loss.
- Flush: occupancy=2, flush=1 with in_valid=1 (0xDD) → next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0; 0xDD never appears.
- Idle hold: occupancy=1 (0x5A), in_valid=0, out_ready=0 for 10 cycles → out_data stays 0x5A, out_valid=1. With PIPE_STALL_CNT_EN, stall_cnt=10.
- Saturation (macro on): hold stall for 70000 cycles → stall_cnt=16'hFFFF, no wrap.
